// File: rtl/fb_scanout.sv
`timescale 1ns/1ps
// fb_scanout
//
// VGA scan-out engine for a 160x120, 3-bit-colour framebuffer. A 640x480
// raster (default timing) is produced at half the system clock. Every
// framebuffer pixel is replicated into a 4x4 block of screen pixels.
//
// Pipeline (one stage per pixel tick, one tick = two clk cycles):
//   p0 : raster counters and the sync/active decode derived from them
//   p1 : framebuffer read address plus registered active/hsync/vsync
//   p2 : VGA pins. Colour comes from the RAM read issued in p1.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   reset        asynchronous, active-high reset
//   rd_addr      framebuffer read address, y*160 + x
//   rd_data      framebuffer colour {R,G,B}; valid one clk after rd_addr
//   VGA_CLK      pixel clock (clk/2)
//   VGA_HS       horizontal sync, active low
//   VGA_VS       vertical sync, active low
//   VGA_BLANK_N  high during active video
//   VGA_SYNC_N   composite sync, tied high
//   VGA_R/G/B    10-bit colour channels
//   frame_start  one-clk pulse when the raster wraps to (0,0)
module fb_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        frame_start
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // One extra bit of headroom so that sync end == total still fits.
  localparam int HW = $clog2(HT + 1);
  localparam int VW = $clog2(VT + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEGIN   = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEGIN   = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  // Framebuffer address of the 4x4 block containing screen pixel (h,v).
  // The row stride of 160 is built as 128 + 32; the largest result
  // (119*160 + 159 = 19199) fits comfortably in 15 bits.
  function automatic logic [14:0] pix_addr(input logic [HW-1:0] h,
                                           input logic [VW-1:0] v);
    logic [14:0] row;
    logic [14:0] col;
    row = 15'(v >> 2);
    col = 15'(h >> 2);
    return (row << 7) + (row << 5) + col;
  endfunction

  // One framebuffer colour bit drives a full-scale or dark channel;
  // outside active video the channel is forced dark.
  function automatic logic [9:0] expand_bit(input logic b, input logic en);
    return (b && en) ? 10'h3FF : 10'h000;
  endfunction

  logic          phase;
  logic          tick;
  logic [HW-1:0] hcount_p0;
  logic [VW-1:0] vcount_p0;
  logic          active_p0;
  logic          hs_n_p0;
  logic          vs_n_p0;
  logic          wrap_p0;

  logic          vld_p1;
  logic          hs_n_p1;
  logic          vs_n_p1;

  logic          vld_p2;
  logic          hs_n_p2;
  logic          vs_n_p2;
  logic [9:0]    r_p2;
  logic [9:0]    g_p2;
  logic [9:0]    b_p2;

  // ---- p0: pixel clock divider and raster counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  assign tick    = phase;
  assign VGA_CLK = phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_p0 <= '0;
      vcount_p0 <= '0;
    end else if (tick) begin
      if (hcount_p0 == H_LAST) begin
        hcount_p0 <= '0;
        if (vcount_p0 == V_LAST) begin
          vcount_p0 <= '0;
        end else begin
          vcount_p0 <= vcount_p0 + VW'(1);
        end
      end else begin
        hcount_p0 <= hcount_p0 + HW'(1);
      end
    end
  end

  assign active_p0 = (hcount_p0 < H_ACT_END) && (vcount_p0 < V_ACT_END);
  assign hs_n_p0   = !((hcount_p0 >= HS_BEGIN) && (hcount_p0 < HS_END));
  assign vs_n_p0   = !((vcount_p0 >= VS_BEGIN) && (vcount_p0 < VS_END));
  assign wrap_p0   = (hcount_p0 == H_LAST) && (vcount_p0 == V_LAST);

  // Pulse is raised by the wrapping tick and dropped by the following
  // (non-tick) edge, giving exactly one clk of width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && wrap_p0;
    end
  end

  // ---- p1: RAM read address and registered timing decode ----
  // The address only moves during active video, so the RAM keeps
  // presenting the last visible pixel through blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      vld_p1  <= 1'b0;
      hs_n_p1 <= 1'b1;
      vs_n_p1 <= 1'b1;
    end else if (tick) begin
      if (active_p0) begin
        rd_addr <= pix_addr(hcount_p0, vcount_p0);
      end
      vld_p1  <= active_p0;
      hs_n_p1 <= hs_n_p0;
      vs_n_p1 <= vs_n_p0;
    end
  end

  // ---- p2: output pins; rd_data is sampled only on ticks ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      hs_n_p2 <= 1'b1;
      vs_n_p2 <= 1'b1;
      r_p2    <= '0;
      g_p2    <= '0;
      b_p2    <= '0;
    end else if (tick) begin
      vld_p2  <= vld_p1;
      hs_n_p2 <= hs_n_p1;
      vs_n_p2 <= vs_n_p1;
      r_p2    <= expand_bit(rd_data[2], vld_p1);
      g_p2    <= expand_bit(rd_data[1], vld_p1);
      b_p2    <= expand_bit(rd_data[0], vld_p1);
    end
  end

  assign VGA_HS      = hs_n_p2;
  assign VGA_VS      = vs_n_p2;
  assign VGA_BLANK_N = vld_p2;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = r_p2;
  assign VGA_G       = g_p2;
  assign VGA_B       = b_p2;

endmodule

// File: tb/tb_fb_scanout.sv
`timescale 1ns/1ps
// Testbench for fb_scanout, using a reduced raster so several full frames
// fit in a short run. Expected pin values after n clk edges are computed
// directly from the raster position reached by the scan.
module tb_fb_scanout;

  localparam int HV  = 48;
  localparam int HF  = 4;
  localparam int HSW = 6;
  localparam int HB  = 6;
  localparam int VV  = 16;
  localparam int VF  = 2;
  localparam int VSW = 3;
  localparam int VB  = 3;
  localparam int HT  = HV + HF + HSW + HB;
  localparam int VT  = VV + VF + VSW + VB;
  localparam int FT  = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data = 3'b000;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [9:0]  VGA_R, VGA_G, VGA_B;

  int vectors = 0;
  int miscompares = 0;
  int fs_count = 0;
  int data_mode = 0;
  logic [2:0] mem [0:19199];

  fb_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer contents for the current data mode.
  function automatic logic [2:0] ram(input int a);
    case (data_mode)
      0:       return (a >= 0 && a < 19200) ? mem[a] : 3'b000;
      1:       return 3'(a % 8);
      default: return 3'b111;
    endcase
  endfunction

  function automatic int addr_of(input int h, input int v);
    return (v / 4) * 160 + h / 4;
  endfunction

  // Address of the most recent visible pixel scanned in the first t ticks.
  function automatic int exp_addr(input int t);
    int p, h, v;
    if (t == 0) return 0;
    p = (t - 1) % FT;
    h = p % HT;
    v = p / HT;
    if (v < VV) return addr_of((h < HV) ? h : HV - 1, v);
    return addr_of(HV - 1, VV - 1);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every output against its expected value n clk edges after
  // reset release (n = 0 also describes the reset state).
  task automatic check_outputs(input int n);
    int t, p, h, v;
    logic act, hs_n, vs_n, fs;
    logic [2:0] pix;
    logic [29:0] rgb;
    t = n / 2;
    p = -1;
    act = 1'b0; hs_n = 1'b1; vs_n = 1'b1; pix = 3'b000;
    if (t >= 2) begin
      p = (t - 2) % FT;
      h = p % HT;
      v = p / HT;
      act  = (h < HV) && (v < VV);
      hs_n = !((h >= HV + HF) && (h < HV + HF + HSW));
      vs_n = !((v >= VV + VF) && (v < VV + VF + VSW));
      if (act) pix = ram(addr_of(h, v));
    end
    rgb = {{10{pix[2]}}, {10{pix[1]}}, {10{pix[0]}}};
    fs = (n % 2 == 0) && (n >= 2) && (((t - 1) % FT) == FT - 1);
    cmp("VGA_CLK", 32'(VGA_CLK), 32'(n % 2));
    cmp("rd_addr", 32'(rd_addr), 32'(exp_addr(t)));
    cmp("VGA_HS", 32'(VGA_HS), 32'(hs_n));
    cmp("VGA_VS", 32'(VGA_VS), 32'(vs_n));
    cmp("VGA_BLANK_N", 32'(VGA_BLANK_N), 32'(act));
    cmp("VGA_SYNC_N", 32'(VGA_SYNC_N), 32'(1));
    cmp("RGB", 32'({VGA_R, VGA_G, VGA_B}), 32'(rgb));
    cmp("frame_start", 32'(frame_start), 32'(fs));
    if (data_mode == 1 && t >= 1 && ((t - 1) % FT) == 4 * HT + 8)
      cmp("addr_h8_v4", 32'(rd_addr), 32'd162);
    if (data_mode == 1 && p == 4 * HT + 8)
      cmp("rgb_h8_v4", 32'({VGA_R, VGA_G, VGA_B}), 32'h000FFC00);
  endtask

  // RAM model: during the half-period before a tick edge the bus carries
  // the word for the current address; before non-tick edges it may carry
  // random junk that the design must ignore.
  task automatic drive_rd(input int n, input bit glitch);
    if (glitch && (n % 2 == 0)) rd_data = 3'($urandom);
    else                        rd_data = ram(int'(rd_addr));
  endtask

  task automatic release_and_run(input int nedges, input bit glitch);
    reset = 1'b0;
    fs_count = 0;
    drive_rd(0, glitch);
    for (int n = 1; n <= nedges; n++) begin
      @(negedge clk);
      check_outputs(n);
      if (frame_start === 1'b1) fs_count++;
      drive_rd(n, glitch);
    end
  endtask

  task automatic async_reset_check();
    #1 reset = 1'b1;
    #1 check_outputs(0);
    repeat (2) @(negedge clk);
    check_outputs(0);
  endtask

  initial begin
    int n_a;
    for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);

    // Reset state, then random framebuffer with junk on non-tick cycles.
    data_mode = 0;
    repeat (3) @(negedge clk);
    check_outputs(0);
    n_a = 4 * FT + $urandom_range(200, 2 * FT - 200);
    release_and_run(n_a, 1'b1);
    cmp("frame_count_a", 32'(fs_count), 32'((n_a / 2) / FT));

    // Asynchronous reset at a random mid-frame point; restart at (0,0).
    async_reset_check();
    data_mode = 1;
    release_and_run(2 * FT + 400, 1'b1);
    cmp("frame_count_b", 32'(fs_count), 32'(((2 * FT + 400) / 2) / FT));

    // Constant white framebuffer: colour only inside active video.
    async_reset_check();
    data_mode = 2;
    release_and_run(2 * FT + 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
